// File: rtl/soc_irq_pkg.sv
// Shared constants and helpers for the SoC interrupt aggregator.
package soc_irq_pkg;

  localparam int MAX_SRC      = 16;
  localparam int ID_VALID_BIT = 15;

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_ID      = 3'd5;
  localparam logic [2:0] ADDR_FORCE   = 3'd6;

  // Index of the lowest set bit (highest priority), 0 when none set.
  function automatic logic [3:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      idx = v[i] ? i[3:0] : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/soc_irq_sync_edge.sv
// Input sampling and rising-edge detection for the irq sources.
// SOC_IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the sample register.
module soc_irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] irq_src,
  output logic [W-1:0] src_q,
  output logic [W-1:0] rise
);

  logic [W-1:0] in_s;
  logic [W-1:0] src_r;
  logic [W-1:0] prev_r;

`ifdef SOC_IRQ_SYNC_EN
  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage synchronizer for sources from foreign clock domains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= irq_src;
      sync_r <= meta_r;
    end
  end

  assign in_s = sync_r;
`else
  assign in_s = irq_src;
`endif

  // Sample register and one-cycle history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_r  <= {W{1'b0}};
      prev_r <= {W{1'b0}};
    end else begin
      src_r  <= in_s;
      prev_r <= src_r;
    end
  end

  assign src_q = src_r;
  assign rise  = src_r & ~prev_r;

endmodule

// File: rtl/soc_irq_aggregator.sv
// Avalon-MM interrupt aggregator: latches, masks and prioritises up to 16 sources.
// Optional macro SOC_IRQ_SYNC_EN adds a 2-flop input synchronizer.
module soc_irq_aggregator
  import soc_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq,
  output logic [3:0]         irq_id
);

  localparam logic [MAX_SRC:0]   ONE_EXT  = 17'd1;
  localparam logic [MAX_SRC-1:0] SRC_MASK = MAX_SRC'((ONE_EXT << NUM_SRC) - ONE_EXT);

  logic [NUM_SRC-1:0] src_q_s;
  logic [NUM_SRC-1:0] rise_n_s;
  logic [MAX_SRC-1:0] src_s;
  logic [MAX_SRC-1:0] rise_s;
  logic [MAX_SRC-1:0] wdata_s;

  logic [MAX_SRC-1:0] enable_r;
  logic [MAX_SRC-1:0] mode_r;
  logic [MAX_SRC-1:0] edge_r;
  logic [15:0]        readdata_r;
  logic               irq_r;
  logic [3:0]         irq_id_r;

  logic               wr_s;
  logic [MAX_SRC-1:0] set_s;
  logic [MAX_SRC-1:0] clr_s;
  logic [MAX_SRC-1:0] mode_chg_s;
  logic [MAX_SRC-1:0] edge_nxt_s;
  logic [MAX_SRC-1:0] pending_s;
  logic [MAX_SRC-1:0] active_s;
  logic               any_s;
  logic [3:0]         id_s;
  logic [15:0]        rd_mux_s;

  soc_irq_sync_edge #(.W(NUM_SRC)) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .src_q   (src_q_s),
    .rise    (rise_n_s)
  );

  assign src_s   = MAX_SRC'(src_q_s);
  assign rise_s  = MAX_SRC'(rise_n_s);
  assign wdata_s = writedata & SRC_MASK;
  assign wr_s    = chipselect & ~write_n;

  // Edge-latch update: a set in the same cycle as a W1C wins; mode change clears.
  always_comb begin
    set_s      = {MAX_SRC{1'b0}};
    clr_s      = {MAX_SRC{1'b0}};
    mode_chg_s = {MAX_SRC{1'b0}};
    if (wr_s && (address == ADDR_FORCE)) begin
      set_s = mode_r & (rise_s | wdata_s);
    end else begin
      set_s = mode_r & rise_s;
    end
    if (wr_s && (address == ADDR_PENDING)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {MAX_SRC{1'b0}};
    end
    if (wr_s && (address == ADDR_MODE)) begin
      mode_chg_s = wdata_s ^ mode_r;
    end else begin
      mode_chg_s = {MAX_SRC{1'b0}};
    end
    edge_nxt_s = ((edge_r & ~clr_s) | set_s) & ~mode_chg_s;
  end

  assign pending_s = (mode_r & edge_r) | (~mode_r & src_s);
  assign active_s  = pending_s & enable_r;
  assign any_s     = |active_s;
  assign id_s      = lowest_set(active_s);

  // Register read multiplexer, evaluated every cycle.
  always_comb begin
    rd_mux_s = 16'h0000;
    case (address)
      ADDR_RAW:     rd_mux_s = src_s;
      ADDR_PENDING: rd_mux_s = pending_s;
      ADDR_ENABLE:  rd_mux_s = enable_r;
      ADDR_MODE:    rd_mux_s = mode_r;
      ADDR_ACTIVE:  rd_mux_s = active_s;
      ADDR_ID: begin
        rd_mux_s               = {12'h000, id_s};
        rd_mux_s[ID_VALID_BIT] = any_s;
      end
      default:      rd_mux_s = 16'h0000;
    endcase
  end

  // Control registers and edge latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_r <= {MAX_SRC{1'b0}};
      mode_r   <= {MAX_SRC{1'b0}};
      edge_r   <= {MAX_SRC{1'b0}};
    end else begin
      edge_r <= edge_nxt_s;
      if (wr_s && (address == ADDR_ENABLE)) begin
        enable_r <= wdata_s;
      end
      if (wr_s && (address == ADDR_MODE)) begin
        mode_r <= wdata_s;
      end
    end
  end

  // Registered outputs toward the bus and the CPU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 16'h0000;
      irq_r      <= 1'b0;
      irq_id_r   <= 4'd0;
    end else begin
      readdata_r <= rd_mux_s;
      irq_r      <= any_s;
      irq_id_r   <= id_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign irq_id   = irq_id_r;

endmodule

// File: tb/tb_soc_irq_aggregator.sv
// Directed self-checking bench for soc_irq_aggregator (NUM_SRC = 8).
module tb_soc_irq_aggregator;
  import soc_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [3:0]  irq_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  soc_irq_aggregator #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check_eq(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; irq_src = 8'h00; address = 3'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
    #12;
    check_eq("rst_irq", {15'd0, irq}, 16'h0000);
    check_eq("rst_rdata", readdata, 16'h0000);
    check_eq("rst_id", {12'd0, irq_id}, 16'h0000);
    @(negedge clk); reset_n = 1'b1;
    rd(ADDR_ENABLE,  16'h0000, "rst_enable");
    rd(ADDR_MODE,    16'h0000, "rst_mode");
    rd(ADDR_PENDING, 16'h0000, "rst_pending");

    // Edge-mode timer source: irq two edges after the input edge
    wr(ADDR_MODE, 16'h0001);
    wr(ADDR_ENABLE, 16'h0001);
    @(negedge clk); irq_src[0] = 1'b1;
    tick(2);
    check_eq("edge_irq_k1", {15'd0, irq}, 16'h0000);
    tick(1);
    check_eq("edge_irq_k2", {15'd0, irq}, 16'h0001);
    rd(ADDR_PENDING, 16'h0001, "edge_pending");
    rd(ADDR_ID,      16'h8000, "edge_id");
    wr(ADDR_PENDING, 16'h0001);
    check_eq("edge_w1c_same", {15'd0, irq}, 16'h0001);
    tick(1);
    check_eq("edge_w1c_low", {15'd0, irq}, 16'h0000);
    irq_src[0] = 1'b0;

    // Level source: W1C has no effect, drop deasserts after two edges
    wr(ADDR_MODE, 16'h0000);
    wr(ADDR_ENABLE, 16'h0008);
    @(negedge clk); irq_src[3] = 1'b1;
    tick(2);
    check_eq("lvl_irq", {15'd0, irq}, 16'h0001);
    check_eq("lvl_irq_id", {12'd0, irq_id}, 16'h0003);
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_PENDING, 16'h0008, "lvl_w1c_pending");
    @(negedge clk); irq_src[3] = 1'b0;
    tick(1);
    check_eq("lvl_drop_k1", {15'd0, irq}, 16'h0001);
    tick(1);
    check_eq("lvl_drop_k2", {15'd0, irq}, 16'h0000);

    // Priority between edge sources 2 and 5
    wr(ADDR_MODE, 16'h0024);
    wr(ADDR_ENABLE, 16'h0024);
    @(negedge clk); irq_src[2] = 1'b1; irq_src[5] = 1'b1;
    tick(3);
    rd(ADDR_ID, 16'h8002, "prio_id_2");
    check_eq("prio_irq_id_2", {12'd0, irq_id}, 16'h0002);
    wr(ADDR_PENDING, 16'h0004);
    rd(ADDR_ID, 16'h8005, "prio_id_5");
    check_eq("prio_irq_id_5", {12'd0, irq_id}, 16'h0005);
    wr(ADDR_PENDING, 16'h0020);
    rd(ADDR_ID, 16'h0000, "prio_id_none");
    check_eq("prio_irq_none", {15'd0, irq}, 16'h0000);
    irq_src[2] = 1'b0; irq_src[5] = 1'b0;

    // Collision: W1C on the same edge the rise sets the latch
    wr(ADDR_MODE, 16'h0002);
    wr(ADDR_ENABLE, 16'h0002);
    @(negedge clk); irq_src[1] = 1'b1;
    @(negedge clk);
    address = ADDR_PENDING; writedata = 16'h0002; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(ADDR_PENDING, 16'h0002, "collide_pending");
    wr(ADDR_PENDING, 16'h0002);
    rd(ADDR_PENDING, 16'h0000, "collide_cleared");
    irq_src[1] = 1'b0;

    // FORCE in edge mode latches; in level mode it does not
    wr(ADDR_MODE, 16'h0010);
    wr(ADDR_ENABLE, 16'h0010);
    wr(ADDR_FORCE, 16'h0010);
    rd(ADDR_PENDING, 16'h0010, "force_pending");
    check_eq("force_irq", {15'd0, irq}, 16'h0001);
    rd(ADDR_FORCE, 16'h0000, "force_reads0");
    wr(ADDR_MODE, 16'h0000);
    wr(ADDR_FORCE, 16'h0010);
    rd(ADDR_PENDING, 16'h0000, "force_lvl_lo");
    @(negedge clk); irq_src[4] = 1'b1;
    tick(2);
    rd(ADDR_PENDING, 16'h0010, "force_lvl_hi");
    @(negedge clk); irq_src[4] = 1'b0;
    tick(2);
    rd(ADDR_PENDING, 16'h0000, "force_lvl_nolatch");

    // RAW/ACTIVE readback, unused bits, address 7
    @(negedge clk); irq_src = 8'hA5;
    tick(2);
    rd(ADDR_RAW, 16'h00A5, "raw");
    wr(ADDR_ENABLE, 16'hFFFF);
    rd(ADDR_ENABLE, 16'h00FF, "enable_mask");
    rd(ADDR_ACTIVE, 16'h00A5, "active");
    rd(ADDR_ID, 16'h8000, "id_src0");
    wr(3'd7, 16'hFFFF);
    rd(3'd7, 16'h0000, "addr7");
    rd(ADDR_ENABLE, 16'h00FF, "enable_again");
    check_eq("pre_rst_irq", {15'd0, irq}, 16'h0001);

    // Reset mid-traffic clears outputs asynchronously
    #2;
    reset_n = 1'b0; irq_src = 8'h00;
    #1;
    check_eq("mid_rst_irq", {15'd0, irq}, 16'h0000);
    check_eq("mid_rst_rdata", readdata, 16'h0000);
    tick(2);
    reset_n = 1'b1;
    rd(ADDR_ENABLE,  16'h0000, "post_rst_enable");
    rd(ADDR_MODE,    16'h0000, "post_rst_mode");
    rd(ADDR_PENDING, 16'h0000, "post_rst_pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_irq_aggregator.md
Name: soc_irq_aggregator

Overview:
- Avalon-MM slave interrupt controller that sits directly downstream of the interval timer and other SoC peripherals.
- Collects up to 16 peripheral irq lines (timer irq on source 0) and latches, masks and prioritises them.
- Presents one registered irq plus the winning source ID to the Nios II CPU.
- Same 16-bit register bus as the peripherals it serves; readdata is registered with 1-cycle latency.

Parameters:
NUM_SRC, 8, number of interrupt sources, legal 1..16; unused register bits read 0 and ignore writes

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
irq_src  in  NUM_SRC  peripheral irq levels, active high, bit 0 = timer
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  registered aggregate interrupt to CPU
irq_id  out  4  index of the highest-priority active source (0 when none)

Behaviour:
- Reset: readdata=0, irq=0, irq_id=0, and all internal registers (src_q, prev_q, edge_latch, ENABLE, MODE) = 0.
- Input sampling: src_q <= irq_src every cycle; prev_q <= src_q; rise = src_q & ~prev_q.
- Effective pending per bit i: MODE[i] ? edge_latch[i] : src_q[i].
- edge_latch[i] set conditions (only while MODE[i]=1):
  - rise[i], or
  - a FORCE write with writedata[i]=1.
- edge_latch[i] clear: W1C write to PENDING with writedata[i]=1. When set and clear hit the same cycle, set wins.
- MODE write: clears edge_latch for every bit whose MODE value changes.
- active = pending & ENABLE.
- irq <= |active; irq_id <= index of the lowest set bit of active (lowest index = highest priority), else 0. Both registered.
- Latency, irq_src rising before edge k:
  - level mode: irq high at edge k+1;
  - edge mode: edge_latch set at k+1, irq high at k+2;
  - deassert (level drop, W1C, ENABLE clear): irq low one edge after the pending/enable change.
- Register map (write = chipselect & ~write_n):
  - 0 RAW (RO): src_q
  - 1 PENDING (R/W1C): effective pending; W1C affects edge-mode bits only
  - 2 ENABLE (RW)
  - 3 MODE (RW): 1 = rising edge, 0 = level
  - 4 ACTIVE (RO)
  - 5 ID (RO): {|active, 11'b0, irq_id}
  - 6 FORCE (WO): reads 0
  - 7: reads 0, writes ignored
- readdata <= mux(address) every cycle, regardless of chipselect.
- Writes take effect at the clock edge.
- A pulse shorter than one clk period may be missed; peripherals hold irq until acknowledged.
- Reset mid-operation: immediately clears all latches; irq drops asynchronously.

Optional Feature:
- Macro: SOC_IRQ_SYNC_EN.
- Defined: irq_src passes through a 2-flop synchronizer before src_q. All input-to-irq latencies grow by 2 cycles. Use this for sources in other clock domains.
- Undefined: irq_src feeds src_q directly, with latencies as stated above.

Decomposition:
- Package soc_irq_pkg holds:
  - register address constants (ADDR_RAW..ADDR_FORCE);
  - MAX_SRC=16;
  - ID_VALID_BIT=15.
- Sub-module soc_irq_sync_edge: vectorised width NUM_SRC, optional synchronizer, src_q/prev_q, rise output.
- Latching, register file and priority encoder stay in the top.

Test Plan:
- Reset: assert reset_n=0 mid-traffic -> irq=0 and readdata=0 immediately; after release, read ENABLE/MODE/PENDING -> 0x0000.
- Edge timer source: MODE=0x0001, ENABLE=0x0001; irq_src[0] high before edge k -> irq=1 at k+2, PENDING=0x0001, ID=0x8000. Write PENDING 0x0001 -> irq=0 one edge later.
- Level source: MODE=0, ENABLE=0x0008, irq_src[3] held high -> irq=1. W1C 0x0008 -> PENDING still 0x0008. Drop irq_src[3] -> irq=0 two edges later.
- Priority: edge mode, sources 2 and 5 pending, ENABLE=0x0024 -> ID=0x8002, irq_id=2. Clear bit 2 -> ID=0x8005. Clear bit 5 -> ID=0x0000, irq=0.
- Collision: W1C of bit 1 in the same cycle as a rise on irq_src[1] (edge mode) -> PENDING bit 1 remains 1.
- FORCE: MODE=0x0010, ENABLE=0x0010, write FORCE 0x0010 -> PENDING=0x0010, irq=1. With MODE=0, the same write -> PENDING bit 4 = irq_src[4], no latch.
